// File: rtl/r4_bfly_seq_if.sv
// Stream/butterfly bundle for the radix-4 butterfly frame sequencer.
// master = sequencer side, slave = source/butterfly/sink side.
`timescale 1ns/1ps
interface r4_bfly_seq_if #(
   parameter int unsigned WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_xr0, in_xr1, in_xr2, in_xr3;
   logic [WIDTH-1:0] in_xi0, in_xi1, in_xi2, in_xi3;

   logic [WIDTH-1:0] bf_xr0, bf_xr1, bf_xr2, bf_xr3;
   logic [WIDTH-1:0] bf_xi0, bf_xi1, bf_xi2, bf_xi3;
   logic             bf_c1, bf_c2, bf_c3;
   logic [WIDTH-1:0] bf_xro, bf_xio;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_re, out_im;
   logic [1:0]       out_idx;
   logic             out_last;

   modport master (
      input  in_valid, in_xr0, in_xr1, in_xr2, in_xr3, in_xi0, in_xi1, in_xi2, in_xi3,
      input  bf_xro, bf_xio, out_ready,
      output in_ready,
      output bf_xr0, bf_xr1, bf_xr2, bf_xr3, bf_xi0, bf_xi1, bf_xi2, bf_xi3,
      output bf_c1, bf_c2, bf_c3,
      output out_valid, out_re, out_im, out_idx, out_last
   );

   modport slave (
      output in_valid, in_xr0, in_xr1, in_xr2, in_xr3, in_xi0, in_xi1, in_xi2, in_xi3,
      output bf_xro, bf_xio, out_ready,
      input  in_ready,
      input  bf_xr0, bf_xr1, bf_xr2, bf_xr3, bf_xi0, bf_xi1, bf_xi2, bf_xi3,
      input  bf_c1, bf_c2, bf_c3,
      input  out_valid, out_re, out_im, out_idx, out_last
   );
endinterface

// File: rtl/r4_bfly_seq.sv
// Frame sequencer for the radix-4 butterfly: holds one 4-point frame, steps the control schedule,
// registers each result and streams it out with backpressure. Optional R4_SEQ_PERF_EN adds frame_cnt.
`timescale 1ns/1ps
module r4_bfly_seq #(
   parameter int unsigned WIDTH = 4,
   parameter logic [11:0] SCHED = 12'hC5A
) (
   input  logic           clk,
   input  logic           rst_n,
   r4_bfly_seq_if.master  bus,
   output logic           busy
`ifdef R4_SEQ_PERF_EN
   ,
   output logic [15:0]    frame_cnt
`endif
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       step_q, step_d;
   logic [2:0]       bf_c_q, bf_c_d;
   logic [WIDTH-1:0] in_xr [4];
   logic [WIDTH-1:0] in_xi [4];
   logic [WIDTH-1:0] bf_xr_q [4];
   logic [WIDTH-1:0] bf_xi_q [4];
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_re_q, out_re_d;
   logic [WIDTH-1:0] out_im_q, out_im_d;
   logic [1:0]       out_idx_q, out_idx_d;
   logic             out_last_q, out_last_d;
   logic             busy_q, busy_d;

   logic             slot_free_c;
   logic             cap_c;
   logic             last_step_c;
   logic             in_ready_c;
   logic             accept_c;

   function automatic logic [2:0] sched_code(input logic [1:0] s);
      case (s)
         2'd0:    return SCHED[2:0];
         2'd1:    return SCHED[5:3];
         2'd2:    return SCHED[8:6];
         default: return SCHED[11:9];
      endcase
   endfunction

   assign in_xr[0] = bus.in_xr0;
   assign in_xr[1] = bus.in_xr1;
   assign in_xr[2] = bus.in_xr2;
   assign in_xr[3] = bus.in_xr3;
   assign in_xi[0] = bus.in_xi0;
   assign in_xi[1] = bus.in_xi1;
   assign in_xi[2] = bus.in_xi2;
   assign in_xi[3] = bus.in_xi3;

   // A result is captured whenever a frame is held and the output slot is empty or draining.
   assign slot_free_c = !out_valid_q || bus.out_ready;
   assign cap_c       = (state_q == RUN) && slot_free_c;
   assign last_step_c = (step_q == 2'd3);
   assign in_ready_c  = rst_n && ((state_q == IDLE) || (cap_c && last_step_c));
   assign accept_c    = bus.in_valid && in_ready_c;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c) state_d = RUN;
         RUN:     if (cap_c && last_step_c && !accept_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      step_d      = step_q;
      out_valid_d = out_valid_q;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;

      // Step returns to 0 after the last step so IDLE always presents the step-0 code.
      if (accept_c) begin
         step_d = 2'd0;
      end else if (cap_c) begin
         step_d = last_step_c ? 2'd0 : step_q + 2'd1;
      end

      if (cap_c) begin
         out_valid_d = 1'b1;
         out_re_d    = bus.bf_xro;
         out_im_d    = bus.bf_xio;
         out_idx_d   = step_q;
         out_last_d  = last_step_c;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      bf_c_d = sched_code(step_d);
      busy_d = (state_d != IDLE) || out_valid_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step_q      <= 2'd0;
         bf_c_q      <= SCHED[2:0];
         out_valid_q <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
         out_idx_q   <= 2'd0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            bf_xr_q[i] <= '0;
            bf_xi_q[i] <= '0;
         end
      end else begin
         step_q      <= step_d;
         bf_c_q      <= bf_c_d;
         out_valid_q <= out_valid_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         if (accept_c) begin
            for (int i = 0; i < 4; i++) begin
               bf_xr_q[i] <= in_xr[i];
               bf_xi_q[i] <= in_xi[i];
            end
         end
      end
   end

`ifdef R4_SEQ_PERF_EN
   logic [15:0] frame_cnt_q;

   // Counts completed frames; wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt_q <= 16'd0;
      end else if (cap_c && last_step_c) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

   assign bus.in_ready  = in_ready_c;
   assign bus.bf_xr0    = bf_xr_q[0];
   assign bus.bf_xr1    = bf_xr_q[1];
   assign bus.bf_xr2    = bf_xr_q[2];
   assign bus.bf_xr3    = bf_xr_q[3];
   assign bus.bf_xi0    = bf_xi_q[0];
   assign bus.bf_xi1    = bf_xi_q[1];
   assign bus.bf_xi2    = bf_xi_q[2];
   assign bus.bf_xi3    = bf_xi_q[3];
   assign bus.bf_c1     = bf_c_q[2];
   assign bus.bf_c2     = bf_c_q[1];
   assign bus.bf_c3     = bf_c_q[0];
   assign bus.out_valid = out_valid_q;
   assign bus.out_re    = out_re_q;
   assign bus.out_im    = out_im_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_last  = out_last_q;
   assign busy          = busy_q;

endmodule
